// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared types and defaults for the memory access stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_access_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_PUSH  = 2'b10,
        OP_POP   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_WAIT_RD = 2'b10,
        ST_RESP    = 2'b11
    } state_t;

    localparam int unsigned DEF_SP_RESET    = 1023;
    localparam int unsigned DEF_STACK_LIMIT = 768;

endpackage

`default_nettype wire

// File: rtl/stack_pointer_unit.sv
// ============================================================================
// Module      : stack_pointer_unit
// Description : Downward-growing stack pointer with full/empty flags.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module stack_pointer_unit #(
    parameter int          ADDR_W      = 32,
    parameter int unsigned SP_RESET    = 1023,
    parameter int unsigned STACK_LIMIT = 768
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_dec,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_sp,
    output logic              o_full,
    output logic              o_empty
);

    localparam logic [ADDR_W-1:0] c_sp_reset = ADDR_W'(SP_RESET);
    localparam logic [ADDR_W-1:0] c_limit    = ADDR_W'(STACK_LIMIT);
    localparam logic [ADDR_W-1:0] c_one      = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_sp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp <= c_sp_reset;
        end else if (i_dec) begin
            r_sp <= r_sp - c_one;
        end else if (i_inc) begin
            r_sp <= r_sp + c_one;
        end
    end

    assign o_sp    = r_sp;
    assign o_full  = (r_sp == c_limit);
    assign o_empty = (r_sp == c_sp_reset);

endmodule

`default_nettype wire

// File: rtl/memory_access_unit.sv
// ============================================================================
// Module      : memory_access_unit
// Description : Memory-stage controller driving DataMemory; owns the stack.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module memory_access_unit
    import mem_access_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int unsigned SP_RESET    = DEF_SP_RESET,
    parameter int unsigned STACK_LIMIT = DEF_STACK_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] sp,
    output logic              flag_full,
    output logic              flag_empty
);

    localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    op_t               r_op;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_we;
    logic              r_re;
    logic              r_resp_valid;
    logic              r_resp_error;
    logic [DATA_W-1:0] r_resp_rdata;

    logic [ADDR_W-1:0] w_sp;
    logic              w_full;
    logic              w_empty;
    logic              w_sp_dec;
    logic              w_sp_inc;
    logic              w_req_err;
    op_t               w_req_op;

    assign w_req_op  = op_t'(req_op);
    assign w_req_err = ((w_req_op == OP_PUSH) && w_full) ||
                       ((w_req_op == OP_POP)  && w_empty);
    assign w_sp_dec  = (r_state == ST_ISSUE) && (r_op == OP_PUSH);
    assign w_sp_inc  = (r_state == ST_ISSUE) && (r_op == OP_POP);

    stack_pointer_unit #(
        .ADDR_W      (ADDR_W),
        .SP_RESET    (SP_RESET),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_sp (
        .clk     (clock),
        .rst     (reset),
        .i_dec   (w_sp_dec),
        .i_inc   (w_sp_inc),
        .o_sp    (w_sp),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Bus values are registered on accept so they are stable for the whole ISSUE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_LOAD;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_we         <= 1'b0;
            r_re         <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_we         <= 1'b0;
            r_re         <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op <= w_req_op;
                        if (w_req_err) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                        end else begin
                            r_state <= ST_ISSUE;
                            case (w_req_op)
                                OP_LOAD: begin
                                    r_mem_addr <= req_addr;
                                    r_re       <= 1'b1;
                                end
                                OP_STORE: begin
                                    r_mem_addr  <= req_addr;
                                    r_mem_wdata <= req_wdata;
                                    r_we        <= 1'b1;
                                end
                                OP_PUSH: begin
                                    r_mem_addr  <= w_sp - c_one;
                                    r_mem_wdata <= req_wdata;
                                    r_we        <= 1'b1;
                                end
                                default: begin
                                    r_mem_addr <= w_sp;
                                    r_re       <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_ISSUE: begin
                    if ((r_op == OP_LOAD) || (r_op == OP_POP)) begin
                        r_state <= ST_WAIT_RD;
                    end else begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                    end
                end
                ST_WAIT_RD: begin
                    r_resp_rdata <= mem_rdata;
                    r_state      <= ST_RESP;
                    r_resp_valid <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Gating by reset keeps a write from committing at the edge that aborts it.
    assign mem_write_en = r_we & ~reset;
    assign mem_read_en  = r_re & ~reset;
    assign mem_address  = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign req_ready    = (r_state == ST_IDLE);
    assign resp_valid   = r_resp_valid;
    assign resp_error   = r_resp_error;
    assign resp_rdata   = r_resp_rdata;
    assign sp           = w_sp;
    assign flag_full    = w_full;
    assign flag_empty   = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_memory_access_unit.sv
// ============================================================================
// Module      : tb_memory_access_unit
// Description : Scoreboard bench for memory_access_unit with a DataMemory model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_memory_access_unit;

    localparam logic [1:0] LD = 2'b00, ST = 2'b01, PU = 2'b10, PO = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [31:0] sp;
    logic        flag_full;
    logic        flag_empty;

    memory_access_unit dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .sp           (sp),
        .flag_full    (flag_full),
        .flag_empty   (flag_empty)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:1023];
    always @(posedge clock) begin
        if (mem_write_en) mem[mem_address[9:0]] <= mem_wdata;
        if (mem_read_en)  mem_rdata <= mem[mem_address[9:0]];
    end

    typedef struct {
        bit          chk;
        logic [31:0] rd;
        bit          err;
    } exp_t;

    exp_t        q[$];
    exp_t        e_m;
    int          checks = 0;
    int          errors = 0;
    int          resp_count = 0;
    int          wr_count = 0;
    int          rd_count = 0;
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pops on every response and watches the memory bus.
    always @(negedge clock) begin
        if (mem_write_en && mem_read_en) begin
            checks++;
            errors++;
            $display("FAIL enable_overlap actual=11 required=not both");
        end
        if (mem_write_en) begin
            wr_count++;
            last_wa = mem_address;
            last_wd = mem_wdata;
        end
        if (mem_read_en) rd_count++;
        if (resp_valid) begin
            resp_count++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp actual=resp_valid required=no response");
            end else begin
                e_m = q.pop_front();
                if (resp_error !== e_m.err) begin
                    errors++;
                    $display("FAIL resp_error actual=%0b required=%0b", resp_error, e_m.err);
                end
                if (e_m.chk) begin
                    checks++;
                    if (resp_rdata !== e_m.rd) begin
                        errors++;
                        $display("FAIL resp_rdata actual=%0h required=%0h", resp_rdata, e_m.rd);
                    end
                end
            end
        end
    end

    task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int lat, input bit chk_rd, input logic [31:0] erd, input bit eerr);
        int n;
        bit seen;
        exp_t e;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 64'(req_ready), 64'd1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        e.chk = chk_rd;
        e.rd  = erd;
        e.err = eerr;
        q.push_back(e);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        seen = 1'b0;
        n = 0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clock);
            if (resp_valid) begin
                seen = 1'b1;
                n = i;
            end
        end
        chk("resp_latency", 64'(n), 64'(lat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc0, rc0, rs0, idx, n;
        logic [31:0] pops [6];
        logic [31:0] pushes [6];
        exp_t e;
        pushes = '{32'd16, 32'd64, 32'd32, 32'd1, 32'd2, 32'd3};
        pops   = '{32'd3, 32'd2, 32'd1, 32'd32, 32'd64, 32'd16};

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_sp", 64'(sp), 64'd1023);
        chk("rst_empty", 64'(flag_empty), 64'd1);
        chk("rst_full", 64'(flag_full), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", 64'(resp_rdata), 64'd0);
        chk("rst_addr", 64'(mem_address), 64'd0);
        chk("rst_en", 64'({mem_write_en, mem_read_en}), 64'd0);

        // STORE then LOAD
        wc0 = wr_count;
        do_req(ST, 32'd1, 32'd32, 2, 1'b0, 32'd0, 1'b0);
        chk("store_wr_pulses", 64'(wr_count - wc0), 64'd1);
        chk("store_addr", 64'(last_wa), 64'd1);
        chk("store_data", 64'(last_wd), 64'd32);
        do_req(LD, 32'd1, 32'd0, 3, 1'b1, 32'd32, 1'b0);

        // Stack push/pop order
        for (int i = 0; i < 6; i++) begin
            do_req(PU, 32'd0, pushes[i], 2, 1'b0, 32'd0, 1'b0);
            if (i == 0) chk("push_first_addr", 64'(last_wa), 64'd1022);
        end
        chk("sp_after_push", 64'(sp), 64'd1017);
        chk("empty_after_push", 64'(flag_empty), 64'd0);
        for (int i = 0; i < 6; i++) do_req(PO, 32'd0, 32'd0, 3, 1'b1, pops[i], 1'b0);
        chk("sp_after_pop", 64'(sp), 64'd1023);
        chk("empty_after_pop", 64'(flag_empty), 64'd1);

        // POP on empty stack
        wc0 = wr_count;
        rc0 = rd_count;
        do_req(PO, 32'd0, 32'd0, 1, 1'b0, 32'd0, 1'b1);
        chk("pop_empty_no_access", 64'((wr_count - wc0) + (rd_count - rc0)), 64'd0);
        chk("pop_empty_sp", 64'(sp), 64'd1023);

        // Reset during ISSUE of a PUSH
        @(negedge clock);
        wc0 = wr_count;
        rs0 = resp_count;
        req_valid = 1'b1;
        req_op    = PU;
        req_wdata = 32'd99;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        chk("rst_issue_we", 64'(mem_write_en), 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_issue_ready", 64'(req_ready), 64'd1);
        chk("rst_issue_sp", 64'(sp), 64'd1023);
        chk("rst_issue_resp", 64'(resp_valid), 64'd0);
        chk("rst_issue_we_after", 64'(mem_write_en), 64'd0);
        repeat (4) @(negedge clock);
        chk("rst_issue_no_resp", 64'(resp_count - rs0), 64'd0);
        chk("rst_issue_no_write", 64'(wr_count - wc0), 64'd0);

        // Continuous req_valid with alternating STORE/LOAD
        idx = 0;
        n = 0;
        rs0 = resp_count;
        while (idx < 6 && n < 60) begin
            @(negedge clock);
            n++;
            req_valid = 1'b1;
            req_op    = (idx % 2 == 0) ? ST : LD;
            req_addr  = 32'd200 + 32'((idx / 2) * 2);
            req_wdata = 32'hA000 + 32'(idx);
            if (resp_valid || mem_write_en || mem_read_en)
                chk("ready_when_busy", 64'(req_ready), 64'd0);
            if (req_ready) begin
                e.chk = (idx % 2 == 1);
                e.rd  = 32'hA000 + 32'(idx - 1);
                e.err = 1'b0;
                q.push_back(e);
                @(posedge clock);
                #1;
                idx++;
            end
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clock);
        chk("b2b_accepts", 64'(idx), 64'd6);
        chk("b2b_resp_count", 64'(resp_count - rs0), 64'd6);

        // Fill stack then overflow
        for (int i = 0; i < 255; i++) do_req(PU, 32'd0, 32'(i), 2, 1'b0, 32'd0, 1'b0);
        chk("fill_last_addr", 64'(last_wa), 64'd768);
        chk("fill_sp", 64'(sp), 64'd768);
        chk("fill_full", 64'(flag_full), 64'd1);
        chk("fill_not_empty", 64'(flag_empty), 64'd0);
        wc0 = wr_count;
        do_req(PU, 32'd0, 32'hDEAD, 1, 1'b0, 32'd0, 1'b1);
        chk("overflow_no_write", 64'(wr_count - wc0), 64'd0);
        chk("overflow_sp", 64'(sp), 64'd768);

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Memory-stage controller of the multi-cycle datapath; sits directly upstream of DataMemory and is its only driver.
- Accepts one LOAD/STORE/PUSH/POP request at a time from the execute stage.
- Owns the stack pointer, generates DataMemory address, data and enable signals, and captures read data into a response register.

Parameters:
- DATA_W, 32, data bus width (matches DataMemory input/output buses)
- ADDR_W, 32, address bus and stack pointer width
- SP_RESET, 1023, stack pointer value after reset (empty stack; stack grows downward)
- STACK_LIMIT, 768, lowest stack address; SP == STACK_LIMIT means the stack is full

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_op  in  2  00 LOAD, 01 STORE, 10 PUSH, 11 POP
- req_addr  in  ADDR_W  LOAD/STORE address; ignored for PUSH/POP
- req_wdata  in  DATA_W  STORE/PUSH data
- resp_valid  out  1  single-cycle completion pulse
- resp_rdata  out  DATA_W  LOAD/POP result; held until the next read completes
- resp_error  out  1  qualified by resp_valid; push-when-full or pop-when-empty
- mem_address  out  ADDR_W  to DataMemory address bus
- mem_wdata  out  DATA_W  to DataMemory input bus
- mem_rdata  in  DATA_W  from DataMemory output bus
- mem_write_en  out  1  DataMemory write enable
- mem_read_en  out  1  DataMemory read enable
- sp  out  ADDR_W  current stack pointer
- flag_full  out  1  sp == STACK_LIMIT
- flag_empty  out  1  sp == SP_RESET

Behaviour:
- Reset values (any cycle, including mid-operation):
  - state = IDLE, sp = SP_RESET, resp_rdata = 0.
  - resp_valid, resp_error, mem_write_en and mem_read_en are all 0; mem_address and mem_wdata are 0.
  - The in-flight request is dropped with no response, and no memory write is issued in the reset cycle.
- DataMemory timing:
  - Writes commit at the rising edge where mem_write_en = 1.
  - Reads: mem_rdata is valid on the cycle after a cycle with mem_read_en = 1.
- States: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - req_ready = 1; all memory enables are 0.
  - On req_valid, latch op/addr/wdata.
  - Error case: PUSH with flag_full, or POP with flag_empty, goes to RESP with resp_error = 1. No memory access occurs and sp is unchanged.
  - Otherwise go to ISSUE.
- ISSUE (exactly one cycle):
  - LOAD: mem_address = addr, mem_read_en = 1, then WAIT_RD.
  - STORE: mem_address = addr, mem_wdata = wdata, mem_write_en = 1, then RESP.
  - PUSH (pre-decrement): mem_address = sp-1, mem_wdata = wdata, mem_write_en = 1; sp <= sp-1 at the edge; then RESP.
  - POP (post-increment): mem_address = sp, mem_read_en = 1; sp <= sp+1 at the edge; then WAIT_RD.
  - mem_write_en and mem_read_en are never both 1.
- WAIT_RD: resp_rdata <= mem_rdata; then RESP.
- RESP: resp_valid = 1 for one cycle, resp_error as latched; then IDLE. req_ready = 0.
- Latency from the accept edge (edge t, where req_valid & req_ready):
  - STORE/PUSH: resp_valid high during cycle t+2.
  - LOAD/POP: resp_valid high during cycle t+3.
  - Error: resp_valid high during cycle t+1.
- Throughput: back-to-back requests are accepted only in IDLE; minimum one IDLE cycle between responses and the next accept.
- Flags:
  - Combinational from sp.
  - flag_full and flag_empty are mutually exclusive for STACK_LIMIT < SP_RESET.
  - A PUSH that makes sp == STACK_LIMIT is legal; the next PUSH errors.
- Arithmetic:
  - sp ± 1 is computed at ADDR_W bits.
  - Wrap-around is unreachable because the error checks block it.
  - LOAD/STORE to stack addresses are allowed; sp is unaffected.

Decomposition:
- Package mem_access_pkg:
  - op encoding enum (OP_LOAD, OP_STORE, OP_PUSH, OP_POP)
  - FSM state enum
  - SP_RESET/STACK_LIMIT defaults
- Sub-module stack_pointer_unit contains:
  - the sp register
  - dec/inc controls
  - flag_full/flag_empty generation
  - synchronous reset to SP_RESET
- The FSM and bus muxing stay in memory_access_unit.

Test Plan:
- STORE addr 1 data 32, then LOAD addr 1:
  - mem_write_en pulses one cycle with mem_address = 1 and mem_wdata = 32.
  - LOAD gives resp_rdata = 32 at t+3 and resp_error = 0.
- PUSH 16, 64, 32, 1, 2, 3, then six POPs:
  - sp goes 1023→1017.
  - POP results are 3, 2, 1, 32, 64, 16.
  - sp returns to 1023 and flag_empty = 1.
- POP on an empty stack: resp_valid at t+1 with resp_error = 1; no mem enable ever asserted; sp stays 1023.
- Fill 255 PUSHes (sp = 768, flag_full = 1), then one more PUSH: resp_error = 1, no write issued, sp stays 768.
- Assert reset in the ISSUE cycle of a PUSH:
  - Next cycle: state IDLE, sp = 1023, no resp_valid, mem_write_en = 0.
- Hold req_valid = 1 continuously with alternating STORE/LOAD:
  - req_ready is high only in IDLE.
  - Each request gets exactly one resp_valid pulse, and enables never overlap.
